instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front end of the 16-bit CPU: owns the program counter, reads instruction words from instruction memory over a request/acknowledge handshake, and presents one instruction at a time to `instruction_decoder` and the controller FSM. It consumes the decoder's `branch_en` and `sximm8` outputs, plus the register-file target value, to compute the next PC. It stops fetching on a HALT opcode (`3'b111`).

## Interface
- `ADDR_W`, 9: PC and memory address width.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `mem_addr`  out  ADDR_W  read address; equals `pc` at all times.
- `mem_rd`  out  1  read request; high only in FETCH.
- `mem_rdata`  in  16  read data; valid when `mem_ack` is high.
- `mem_ack`  in  1  read complete; honoured only while `mem_rd` is high.
- `instr`  out  16  instruction register; drives the decoder `instruction` input.
- `instr_valid`  out  1  `instr` is presented; high only in ISSUE.
- `instr_ready`  in  1  controller has finished executing `instr`.
- `branch_en`  in  2  from decoder: 00 = sequential, 01 = PC-relative, 10 = register target, 11 = treated as 00.
- `sximm8`  in  16  from decoder; branch offset.
- `reg_target`  in  16  register value for BX/BLX targets.
- `pc_link`  out  ADDR_W  PC+1 of the instruction in `instr`; BL/BLX link value.
- `halt`  out  1  HALT retired; sticky until reset.
- `retired_count`  out  16  retired-instruction counter (see Configuration).

## Operation
- States: RST, FETCH, ISSUE, HALTED.
- Reset (`reset_n` = 0 at an edge) has priority over everything and sets:
  - state = RST, `pc` = `RESET_PC`, `instr` = 16'h0000.
  - `mem_rd` = 0, `instr_valid` = 0, `halt` = 0, `retired_count` = 0.
  - `pc_link` = `RESET_PC`+1.
- RST → FETCH unconditionally on the next edge.
- FETCH: `mem_rd` = 1 with `mem_addr` = `pc`.
  - On an edge with `mem_ack` = 1: `instr` ← `mem_rdata`, then → ISSUE.
  - Otherwise hold FETCH; the wait is unbounded.
- ISSUE: `instr_valid` = 1 and `instr` is stable. An edge with `instr_ready` = 1 retires the instruction:
  - If `instr[15:13]` = 3'b111: `pc` is unchanged, `halt` ← 1, → HALTED.
  - Otherwise `pc` is loaded by `branch_en`, then → FETCH:
    - 01: `pc` ← `pc` + 1 + `sximm8[ADDR_W-1:0]`.
    - 10: `pc` ← `reg_target[ADDR_W-1:0]`.
    - 00 or 11: `pc` ← `pc` + 1.
- HALTED: `mem_rd` = 0 and `instr_valid` = 0; all inputs are ignored until reset.
- `pc_link` is combinational: `pc` + 1.
- All PC arithmetic is modulo 2^ADDR_W. `pc` = 2^ADDR_W−1 with sequential flow wraps to 0; negative offsets wrap the same way.
- `branch_en`, `sximm8` and `reg_target` are sampled only at the retiring edge. The decoder computes them combinationally from `instr`, so they are settled by then.

## Timing
- `mem_rd` and `instr_valid` are decoded from the state register; no combinational path runs from `mem_ack` or `instr_ready` to any output.
- Minimum throughput is 2 cycles per instruction: one FETCH cycle with `mem_ack` already high, then one ISSUE cycle with `instr_ready` already high.
- The first `mem_rd` is asserted 1 cycle after `reset_n` rises.
- The new `pc` appears on `mem_addr` in the cycle after the retiring edge.
- Ignored inputs:
  - `mem_ack` outside FETCH.
  - `instr_ready` outside ISSUE.
  - `instr_ready` and `mem_ack` high together: only the one belonging to the current state acts.
- Reset during FETCH abandons the read, and the memory must tolerate the dropped request. Reset during ISSUE discards `instr`.

## Configuration
- `IFETCH_RETIRE_CNT_EN` defined:
  - `retired_count` increments on every retiring edge, HALT included.
  - It saturates at 16'hFFFF and resets to 0.
- `IFETCH_RETIRE_CNT_EN` undefined: `retired_count` is tied to 16'h0000 and no counter flops exist.

## Test plan
- Reset, then memory with 0 wait states and `instr_ready` held high: `mem_addr` steps 0,1,2,3 every 2 cycles, and `instr` matches each memory word.
- Memory with 3 wait states: `mem_rd` is held high for 4 cycles per word, and `instr_valid` does not rise until the cycle after the `mem_ack` edge.
- At `pc` = 5, retire with `branch_en` = 01 and `sximm8` = 16'hFFFD: next `mem_addr` = 3. At `pc` = 2, retire with `branch_en` = 10 and `reg_target` = 16'h0040: next `mem_addr` = 0x40, and `pc_link` was 3.
- `ADDR_W` = 9 with `pc` = 511, sequential: next `mem_addr` = 0.
- Fetch 16'hE000: after retiring, `halt` = 1, `mem_rd` stays 0 for 20 cycles, and `retired_count` = N+1 with the macro defined (0 without).
- Assert `reset_n` = 0 mid-FETCH while `mem_ack` is pulsed: all outputs return to their reset values, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
// Bundles the instruction-memory read port and the instruction issue
// handshake towards the decoder/controller.
// The fetch unit connects through the master modport.
// The memory and controller side connects through the slave modport.
interface instruction_fetch_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_rdata;
    logic              mem_ack;
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata,
        input  mem_ack,
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata,
        output mem_ack,
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch
// CPU front end. This module:
//   - owns the program counter,
//   - reads one instruction word at a time over a request/acknowledge handshake,
//   - holds that word for the controller until it retires,
//   - stops for good on a HALT opcode (3'b111).
// Optional feature, macro IFETCH_RETIRE_CNT_EN: adds a saturating
// retired-instruction counter. Without the macro, retired_count is tied to zero.
module instruction_fetch #(
    parameter int          ADDR_W   = 9,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    instruction_fetch_if.master  bus,
    input  logic [1:0]           branch_en,
    input  logic [15:0]          sximm8,
    input  logic [15:0]          reg_target,
    output logic [ADDR_W-1:0]    pc_link,
    output logic                 halt,
    output logic [15:0]          retired_count
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [2:0]        OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        ST_RST,
        ST_FETCH,
        ST_ISSUE,
        ST_HALTED
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] branch_pc;
    logic [15:0]       instr_reg;
    logic [15:0]       instr_next;
    logic              halt_reg;
    logic              halt_next;
    logic              retire;
    logic              unused_bits;

    // Next PC after a non-HALT retirement.
    // All arithmetic wraps at 2^ADDR_W.
    // branch_en 11 is treated like 00.
    always_comb begin
        branch_pc = pc + 1'b1;
        case (branch_en)
            2'b01:   branch_pc = pc + 1'b1 + sximm8[ADDR_W-1:0];
            2'b10:   branch_pc = reg_target[ADDR_W-1:0];
            default: branch_pc = pc + 1'b1;
        endcase
    end

    // Next-state logic.
    // mem_ack only matters in FETCH.
    // instr_ready only matters in ISSUE.
    // HALTED ignores everything until reset.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr_reg;
        halt_next  = halt_reg;
        retire     = 1'b0;
        case (state)
            ST_RST: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    instr_next = bus.mem_rdata;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.instr_ready) begin
                    retire = 1'b1;
                    if (instr_reg[15:13] == OP_HALT) begin
                        halt_next  = 1'b1;
                        state_next = ST_HALTED;
                    end else begin
                        pc_next    = branch_pc;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RST;
            end
        endcase
    end

    // State, PC, instruction and halt registers.
    // Reset takes priority and abandons any read in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_RST;
            pc        <= PC_INIT;
            instr_reg <= 16'h0000;
            halt_reg  <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            instr_reg <= instr_next;
            halt_reg  <= halt_next;
        end
    end

    // Every output comes from registers.
    // There is no path from mem_ack or instr_ready to any output.
    assign bus.mem_addr    = pc;
    assign bus.mem_rd      = (state == ST_FETCH);
    assign bus.instr       = instr_reg;
    assign bus.instr_valid = (state == ST_ISSUE);
    assign pc_link         = pc + 1'b1;
    assign halt            = halt_reg;

`ifdef IFETCH_RETIRE_CNT_EN
    logic [15:0] retire_cnt;

    // Count every retirement, HALT included.
    // The counter sticks at 16'hFFFF instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            retire_cnt <= 16'h0000;
        end else if (retire && (retire_cnt != 16'hFFFF)) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end

    assign retired_count = retire_cnt;
    assign unused_bits   = ^{sximm8[15:ADDR_W], reg_target[15:ADDR_W]};
`else
    assign retired_count = 16'h0000;
    assign unused_bits   = ^{sximm8[15:ADDR_W], reg_target[15:ADDR_W], retire};
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
// Bench for instruction_fetch. The bench plays two roles:
//   - the instruction memory, with a chosen number of wait states;
//   - the decoder/controller, with a chosen number of stall cycles.
// It checks the DUT in three ways:
//   - a table of hand-computed vectors;
//   - randomized instructions checked against an arithmetic PC model;
//   - hand-written HALT and reset sequences.
module tb_instruction_fetch;

    localparam int          ADDR_W   = 9;
    localparam int unsigned RESET_PC = 0;
    localparam int          PC_MOD   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        branch_en;
    logic [15:0]       sximm8;
    logic [15:0]       reg_target;
    logic [ADDR_W-1:0] pc_link;
    logic              halt;
    logic [15:0]       retired_count;

    int check_count   = 0;
    int pass_count    = 0;
    int cycle_count   = 0;
    int model_pc      = 0;
    int model_retired = 0;

    typedef struct {
        logic [15:0] word;
        int          wait_states;
        int          ready_delay;
        logic [1:0]  ben;
        logic [15:0] simm;
        logic [15:0] rt;
        int          exp_pc;
        int          exp_next;
        int          exp_link;
    } vec_t;

    vec_t vecs[13];

    instruction_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_fetch #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .branch_en     (branch_en),
        .sximm8        (sximm8),
        .reg_target    (reg_target),
        .pc_link       (pc_link),
        .halt          (halt),
        .retired_count (retired_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure per-instruction latency.
    always @(posedge clk) cycle_count <= cycle_count + 1;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference next-PC rule, computed with integer modulo arithmetic.
    function automatic int ref_next_pc(input int pc, input logic [1:0] ben,
                                       input logic [15:0] simm, input logic [15:0] rt);
        case (ben)
            2'b01:   return (pc + 1 + int'(simm)) % PC_MOD;
            2'b10:   return int'(rt) % PC_MOD;
            default: return (pc + 1) % PC_MOD;
        endcase
    endfunction

    function automatic int exp_retired();
`ifdef IFETCH_RETIRE_CNT_EN
        return (model_retired > 65535) ? 65535 : model_retired;
`else
        return 0;
`endif
    endfunction

    // Apply reset for one edge and check every output against its reset value.
    // ack_pulse drives mem_ack and instr_ready high during that edge.
    // Then release reset and check that fetching starts one cycle later.
    task automatic do_reset(input logic ack_pulse);
        reset_n         = 1'b0;
        bus.mem_ack     = ack_pulse;
        bus.mem_rdata   = 16'hDEAD;
        bus.instr_ready = ack_pulse;
        tick();
        checkOutput("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("rst_instr", 32'(bus.instr), 32'h0000);
        checkOutput("rst_halt", 32'(halt), 32'd0);
        checkOutput("rst_retired_count", 32'(retired_count), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'(RESET_PC % PC_MOD));
        checkOutput("rst_pc_link", 32'(pc_link), 32'((RESET_PC + 1) % PC_MOD));
        reset_n         = 1'b1;
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b0;
        model_pc        = int'(RESET_PC) % PC_MOD;
        model_retired   = 0;
        tick();
        checkOutput("first_mem_rd", 32'(bus.mem_rd), 32'd1);
        checkOutput("first_mem_addr", 32'(bus.mem_addr), 32'(model_pc));
    endtask

    // Run one instruction through FETCH and ISSUE.
    // Precondition: the DUT is in the first cycle of FETCH.
    // Memory answers after wait_states cycles.
    // The controller retires after ready_delay stall cycles.
    task automatic applyStimulus(input logic [15:0] word, input int wait_states, input int ready_delay,
                                 input logic [1:0] ben, input logic [15:0] simm, input logic [15:0] rt,
                                 input int exp_next, input int exp_link);
        int start_cycle;
        start_cycle = cycle_count;
        checkOutput("fetch_mem_rd", 32'(bus.mem_rd), 32'd1);
        checkOutput("fetch_mem_addr", 32'(bus.mem_addr), 32'(model_pc));
        checkOutput("fetch_instr_valid", 32'(bus.instr_valid), 32'd0);
        branch_en  = 2'($urandom);
        sximm8     = 16'($urandom);
        reg_target = 16'($urandom);
        for (int w = 0; w < wait_states; w++) begin
            bus.mem_ack     = 1'b0;
            bus.mem_rdata   = 16'($urandom);
            bus.instr_ready = 1'($urandom);
            tick();
            checkOutput("wait_mem_rd", 32'(bus.mem_rd), 32'd1);
            checkOutput("wait_instr_valid", 32'(bus.instr_valid), 32'd0);
        end
        bus.mem_ack     = 1'b1;
        bus.mem_rdata   = word;
        bus.instr_ready = 1'($urandom);
        tick();
        checkOutput("issue_instr_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("issue_mem_rd", 32'(bus.mem_rd), 32'd0);
        checkOutput("issue_instr", 32'(bus.instr), 32'(word));
        checkOutput("issue_pc_link", 32'(pc_link), 32'(exp_link));
        branch_en  = ben;
        sximm8     = simm;
        reg_target = rt;
        for (int d = 0; d < ready_delay; d++) begin
            bus.instr_ready = 1'b0;
            bus.mem_ack     = 1'($urandom);
            bus.mem_rdata   = 16'($urandom);
            tick();
            checkOutput("stall_instr_valid", 32'(bus.instr_valid), 32'd1);
            checkOutput("stall_instr", 32'(bus.instr), 32'(word));
        end
        bus.instr_ready = 1'b1;
        bus.mem_ack     = 1'($urandom);
        tick();
        bus.instr_ready = 1'b0;
        bus.mem_ack     = 1'b0;
        model_retired++;
        if (word[15:13] == 3'b111) begin
            checkOutput("halt_flag", 32'(halt), 32'd1);
            checkOutput("halt_mem_rd", 32'(bus.mem_rd), 32'd0);
            checkOutput("halt_instr_valid", 32'(bus.instr_valid), 32'd0);
            checkOutput("halt_mem_addr", 32'(bus.mem_addr), 32'(model_pc));
        end else begin
            model_pc = exp_next;
            checkOutput("next_mem_rd", 32'(bus.mem_rd), 32'd1);
            checkOutput("next_mem_addr", 32'(bus.mem_addr), 32'(exp_next));
            checkOutput("next_halt", 32'(halt), 32'd0);
        end
        checkOutput("retired_count", 32'(retired_count), 32'(exp_retired()));
        checkOutput("instr_cycles", 32'(cycle_count - start_cycle), 32'(wait_states + ready_delay + 2));
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] s;
        logic [15:0] r;
        logic [1:0]  b;
        int          nxt;

        //            word      ws rd ben    simm      rt        pc      next    link
        vecs[0]  = '{16'h1111, 0, 0, 2'b00, 16'h0000, 16'h0000, 0,      1,      1};
        vecs[1]  = '{16'h2222, 0, 0, 2'b00, 16'h0000, 16'h0000, 1,      2,      2};
        vecs[2]  = '{16'h3333, 0, 0, 2'b00, 16'h0000, 16'h0000, 2,      3,      3};
        vecs[3]  = '{16'h4444, 3, 0, 2'b11, 16'hFFFF, 16'h0123, 3,      4,      4};
        vecs[4]  = '{16'h5555, 3, 2, 2'b00, 16'h0000, 16'h0000, 4,      5,      5};
        vecs[5]  = '{16'h6666, 1, 0, 2'b01, 16'hFFFD, 16'h0000, 5,      3,      6};
        vecs[6]  = '{16'h7777, 0, 1, 2'b01, 16'hFFFE, 16'h0000, 3,      2,      4};
        vecs[7]  = '{16'h8888, 2, 0, 2'b10, 16'h0000, 16'h0040, 2,      'h40,   3};
        vecs[8]  = '{16'h9999, 0, 0, 2'b10, 16'h0000, 16'hFFFF, 'h40,   'h1FF,  'h41};
        vecs[9]  = '{16'hAAAA, 0, 0, 2'b00, 16'h0000, 16'h0000, 'h1FF,  0,      0};
        vecs[10] = '{16'hBBBB, 1, 1, 2'b01, 16'h7E05, 16'h0000, 0,      6,      1};
        vecs[11] = '{16'hCCCC, 0, 0, 2'b01, 16'hFFF0, 16'h0000, 6,      'h1F7,  7};
        vecs[12] = '{16'hDDDD, 0, 0, 2'b01, 16'h0010, 16'h0000, 'h1F7,  8,      'h1F8};

        reset_n         = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 16'h0000;
        bus.instr_ready = 1'b0;
        branch_en       = 2'b00;
        sximm8          = 16'h0000;
        reg_target      = 16'h0000;

        $display("[TB] reset");
        do_reset(1'b0);

        $display("[TB] table vectors");
        for (int i = 0; i < 13; i++) begin
            checkOutput("vec_pc", 32'(bus.mem_addr), 32'(vecs[i].exp_pc));
            applyStimulus(vecs[i].word, vecs[i].wait_states, vecs[i].ready_delay, vecs[i].ben,
                          vecs[i].simm, vecs[i].rt, vecs[i].exp_next, vecs[i].exp_link);
        end

        $display("[TB] randomized instructions");
        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
            while (w[15:13] == 3'b111) w = 16'($urandom);
            b   = 2'($urandom);
            s   = 16'($urandom);
            r   = 16'($urandom);
            nxt = ref_next_pc(model_pc, b, s, r);
            applyStimulus(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), b, s, r,
                          nxt, (model_pc + 1) % PC_MOD);
        end

        $display("[TB] halt");
        applyStimulus(16'hE000, 1, 1, 2'b01, 16'h0005, 16'h0000, model_pc, (model_pc + 1) % PC_MOD);
        for (int c = 0; c < 20; c++) begin
            bus.mem_ack     = 1'($urandom);
            bus.mem_rdata   = 16'($urandom);
            bus.instr_ready = 1'($urandom);
            branch_en       = 2'($urandom);
            tick();
            checkOutput("halted_mem_rd", 32'(bus.mem_rd), 32'd0);
            checkOutput("halted_halt", 32'(halt), 32'd1);
        end
        checkOutput("halted_instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("halted_retired_count", 32'(retired_count), 32'(exp_retired()));

        $display("[TB] reset from halted");
        do_reset(1'b1);
        applyStimulus(16'h0101, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 1);
        applyStimulus(16'h0202, 1, 0, 2'b00, 16'h0000, 16'h0000, 2, 2);

        $display("[TB] reset mid-fetch");
        bus.mem_ack = 1'b0;
        tick();
        checkOutput("midfetch_mem_rd", 32'(bus.mem_rd), 32'd1);
        checkOutput("midfetch_mem_addr", 32'(bus.mem_addr), 32'd2);
        do_reset(1'b1);
        applyStimulus(16'h0303, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
